laser_control: RTL and testbench

//  Control FSM for the laser datapath. Drives every datapath enable/select and consumes its

---
 rtl/laser_pkg.sv | 37 +++
 rtl/laser_control_if.sv | 36 +++
 rtl/laser_bounce_counter.sv | 39 +++
 rtl/laser_control.sv | 153 +++++++++++++++
 tb/tb_laser_control.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/laser_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | laser_pkg: shared states, select codes and limits for the laser datapath
// | and its controller. Rev 1.0
// +-----------------------------------------------------------------------------
package laser_pkg;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_INIT    = 4'd1,
    ST_DRAW    = 4'd2,
    ST_WAIT    = 4'd3,
    ST_ERASE   = 4'd4,
    ST_PROBE_X = 4'd5,
    ST_PROBE_Y = 4'd6,
    ST_PROBE_D = 4'd7,
    ST_MOVE    = 4'd8,
    ST_DONE    = 4'd9
  } state_e;

  localparam logic [1:0] POS_LOAD = 2'd0;
  localparam logic [1:0] POS_INC  = 2'd1;
  localparam logic [1:0] POS_DEC  = 2'd2;
  localparam logic [1:0] POS_HOLD = 2'd3;

  localparam logic [1:0] OBS_NONE = 2'd0;
  localparam logic [1:0] OBS_X    = 2'd1;
  localparam logic [1:0] OBS_Y    = 2'd2;
  localparam logic [1:0] OBS_D    = 2'd3;

  localparam logic COL_BG    = 1'b0;
  localparam logic COL_LASER = 1'b1;

  localparam logic [7:0] BOUNCE_SAT = 8'hFF;

endpackage
`default_nettype wire

// File: rtl/laser_control_if.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | laser_control_if: controller <-> datapath enables, selects and status flags.
// | Rev 1.0
// +-----------------------------------------------------------------------------
interface laser_control_if;
  logic       xdir;
  logic       ydir;
  logic       timer_done;
  logic       obstacle;
  logic       en_xpos;
  logic       en_ypos;
  logic [1:0] s_xpos;
  logic [1:0] s_ypos;
  logic       en_xdir;
  logic       en_ydir;
  logic       s_xdir;
  logic       s_ydir;
  logic       en_timer;
  logic       s_timer;
  logic       s_color;
  logic [1:0] s_obs_xy;

  modport master (
    input  xdir, ydir, timer_done, obstacle,
    output en_xpos, en_ypos, s_xpos, s_ypos, en_xdir, en_ydir, s_xdir, s_ydir,
           en_timer, s_timer, s_color, s_obs_xy
  );

  modport slave (
    output xdir, ydir, timer_done, obstacle,
    input  en_xpos, en_ypos, s_xpos, s_ypos, en_xdir, en_ydir, s_xdir, s_ydir,
           en_timer, s_timer, s_color, s_obs_xy
  );
endinterface
`default_nettype wire

// File: rtl/laser_bounce_counter.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | laser_bounce_counter: 8-bit saturating bounce counter with synchronous clear.
// | Rev 1.0
// +-----------------------------------------------------------------------------
module laser_bounce_counter
  import laser_pkg::*;
(
  input  wire logic       clk,
  input  wire logic       resetn,
  input  wire logic       clear,
  input  wire logic       inc,
  output logic      [7:0] count
);

  logic [7:0] count_q;
  logic [7:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = 8'd0;
    end else if (inc && (count_q != BOUNCE_SAT)) begin
      count_d = count_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count_q <= 8'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule
`default_nettype wire

// File: rtl/laser_control.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | laser_control: sequences draw -> wait -> erase -> probe -> move for the laser
// | datapath, generates the VGA plot strobe and counts bounces. Rev 1.0
// +-----------------------------------------------------------------------------
module laser_control
  import laser_pkg::*;
#(
  parameter logic [7:0] MAX_BOUNCES = 8'd255
) (
  input  wire logic            clk,
  input  wire logic            resetn,
  input  wire logic            go,
  input  wire logic            pause,
  laser_control_if.master      dp,
  output logic                 plot,
  output logic                 busy,
  output logic                 done,
  output logic           [7:0] bounce_count
);

  state_e state_q;
  state_e state_d;
  logic   bounced_q;
  logic   bounced_d;
  logic   cnt_clear;
  logic   cnt_inc;

  laser_bounce_counter u_bounce_counter (
    .clk    (clk),
    .resetn (resetn),
    .clear  (cnt_clear),
    .inc    (cnt_inc),
    .count  (bounce_count)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      bounced_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      bounced_q <= bounced_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    bounced_d   = bounced_q;
    cnt_clear   = 1'b0;
    cnt_inc     = 1'b0;
    dp.en_xpos  = 1'b0;
    dp.en_ypos  = 1'b0;
    dp.s_xpos   = POS_LOAD;
    dp.s_ypos   = POS_LOAD;
    dp.en_xdir  = 1'b0;
    dp.en_ydir  = 1'b0;
    dp.s_xdir   = 1'b0;
    dp.s_ydir   = 1'b0;
    dp.en_timer = 1'b0;
    dp.s_timer  = 1'b0;
    dp.s_color  = COL_LASER;
    dp.s_obs_xy = OBS_NONE;
    plot        = 1'b0;
    done        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (go) state_d = ST_INIT;
      end
      ST_INIT: begin
        dp.en_xpos  = 1'b1;
        dp.en_ypos  = 1'b1;
        dp.en_xdir  = 1'b1;
        dp.en_ydir  = 1'b1;
        dp.en_timer = 1'b1;
        cnt_clear   = 1'b1;
        state_d     = ST_DRAW;
      end
      ST_DRAW: begin
        plot    = 1'b1;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        dp.en_timer = !pause;
        dp.s_timer  = 1'b1;
        // Expiry wins over pause so a paused laser still advances once the delay is up.
        if (dp.timer_done) state_d = ST_ERASE;
      end
      ST_ERASE: begin
        plot       = 1'b1;
        dp.s_color = COL_BG;
        bounced_d  = 1'b0;
        state_d    = ST_PROBE_X;
      end
      ST_PROBE_X: begin
        dp.s_obs_xy = OBS_X;
        if (dp.obstacle) begin
          dp.en_xdir = 1'b1;
          dp.s_xdir  = 1'b1;
          cnt_inc    = 1'b1;
          bounced_d  = 1'b1;
        end
        state_d = ST_PROBE_Y;
      end
      ST_PROBE_Y: begin
        dp.s_obs_xy = OBS_Y;
        if (dp.obstacle) begin
          dp.en_ydir = 1'b1;
          dp.s_ydir  = 1'b1;
          cnt_inc    = 1'b1;
          bounced_d  = 1'b1;
        end
        state_d = ST_PROBE_D;
      end
      ST_PROBE_D: begin
        dp.s_obs_xy = OBS_D;
        // Only a pure corner hit reverses both axes; an axis bounce already handled it.
        if (dp.obstacle && !bounced_q) begin
          dp.en_xdir = 1'b1;
          dp.en_ydir = 1'b1;
          dp.s_xdir  = 1'b1;
          dp.s_ydir  = 1'b1;
          cnt_inc    = 1'b1;
        end
        state_d = ST_MOVE;
      end
      ST_MOVE: begin
        dp.en_xpos  = 1'b1;
        dp.en_ypos  = 1'b1;
        dp.s_xpos   = dp.xdir ? POS_DEC : POS_INC;
        dp.s_ypos   = dp.ydir ? POS_DEC : POS_INC;
        dp.en_timer = 1'b1;
        if ((MAX_BOUNCES != 8'd0) && (bounce_count >= MAX_BOUNCES)) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_DRAW;
        end
      end
      ST_DONE: begin
        done = 1'b1;
        if (!go) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign busy = (state_q != ST_IDLE) && (state_q != ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_laser_control.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | tb_laser_control: random stimulus against a step-sequence reference model,
// | with a queued scoreboard checked by an independent monitor. Rev 1.0
// +-----------------------------------------------------------------------------
module tb_laser_control;

  localparam int MAXB   = 2;
  localparam int NCYC   = 4000;

  logic       clk = 1'b0;
  logic       resetn;
  logic       go;
  logic       pause;
  logic       plot;
  logic       busy;
  logic       done;
  logic [7:0] bounce_count;

  always #5 clk = ~clk;

  laser_control_if dp ();

  laser_control #(.MAX_BOUNCES(8'd2)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .go           (go),
    .pause        (pause),
    .dp           (dp),
    .plot         (plot),
    .busy         (busy),
    .done         (done),
    .bounce_count (bounce_count)
  );

  typedef struct {
    logic [18:0] ctrl;
    logic [7:0]  cnt;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference model: run phase plus position within the 7-step work sequence
  // (0 draw, 1 wait, 2 erase, 3 probe-x, 4 probe-y, 5 probe-d, 6 move).
  int mode = 0;   // 0 idle, 1 init, 2 stepping, 3 done
  int step = 0;
  int m_count = 0;
  bit m_bounced = 1'b0;
  bit dp_x = 1'b0;
  bit dp_y = 1'b0;

  function automatic exp_t build_expected(int cyc);
    exp_t e;
    logic en_xp = 0, en_yp = 0, en_xd = 0, en_yd = 0, sxd = 0, syd = 0;
    logic en_t = 0, s_t = 0, col = 1, pl = 0, bz = 0, dn = 0;
    logic [1:0] sxp = 0, syp = 0, obs = 0;
    if (resetn) begin
      if (mode == 1) begin
        en_xp = 1; en_yp = 1; en_xd = 1; en_yd = 1; en_t = 1; bz = 1;
      end else if (mode == 3) begin
        dn = 1;
      end else if (mode == 2) begin
        bz = 1;
        case (step)
          0: pl = 1;
          1: begin en_t = !pause; s_t = 1; end
          2: begin pl = 1; col = 0; end
          3: begin obs = 1; if (dp.obstacle) begin en_xd = 1; sxd = 1; end end
          4: begin obs = 2; if (dp.obstacle) begin en_yd = 1; syd = 1; end end
          5: begin
            obs = 3;
            if (dp.obstacle && !m_bounced) begin en_xd = 1; en_yd = 1; sxd = 1; syd = 1; end
          end
          default: begin
            en_xp = 1; en_yp = 1; en_t = 1;
            sxp = dp_x ? 2'd2 : 2'd1;
            syp = dp_y ? 2'd2 : 2'd1;
          end
        endcase
      end
    end
    e.ctrl = {en_xp, en_yp, sxp, syp, en_xd, en_yd, sxd, syd, en_t, s_t, col, obs, pl, bz, dn};
    e.cnt  = resetn ? 8'(m_count) : 8'd0;
    e.cyc  = cyc;
    return e;
  endfunction

  task automatic bump();
    if (m_count < 255) m_count++;
  endtask

  task automatic advance();
    if (!resetn) begin
      mode = 0; step = 0; m_count = 0; m_bounced = 0;
      return;
    end
    case (mode)
      0: if (go) mode = 1;
      1: begin
        m_count = 0;
        dp_x = 1'($urandom_range(0, 1));
        dp_y = 1'($urandom_range(0, 1));
        mode = 2; step = 0;
      end
      3: if (!go) mode = 0;
      default: begin
        case (step)
          0: step = 1;
          1: if (dp.timer_done) step = 2;
          2: begin m_bounced = 0; step = 3; end
          3: begin
            if (dp.obstacle) begin dp_x = ~dp_x; bump(); m_bounced = 1; end
            step = 4;
          end
          4: begin
            if (dp.obstacle) begin dp_y = ~dp_y; bump(); m_bounced = 1; end
            step = 5;
          end
          5: begin
            if (dp.obstacle && !m_bounced) begin dp_x = ~dp_x; dp_y = ~dp_y; bump(); end
            step = 6;
          end
          default: begin
            mode = (m_count >= MAXB) ? 3 : 2;
            step = 0;
          end
        endcase
      end
    endcase
  endtask

  // Stimulus: inputs change on the falling edge, the model steps on the rising edge.
  initial begin
    bit did_py_reset = 0;
    exp_t e;
    resetn = 1'b0; go = 1'b0; pause = 1'b0;
    dp.xdir = 1'b0; dp.ydir = 1'b0; dp.timer_done = 1'b0; dp.obstacle = 1'b0;
    for (int c = 0; c < NCYC; c++) begin
      @(negedge clk);
      if (c < 2) begin
        resetn = 1'b0;
      end else if (!did_py_reset && c > 200 && mode == 2 && step == 4) begin
        resetn = 1'b0;
        did_py_reset = 1;
      end else begin
        resetn = ($urandom_range(0, 299) != 0);
      end
      go            = 1'($urandom_range(0, 1));
      pause         = 1'($urandom_range(0, 1));
      dp.timer_done = ($urandom_range(0, 3) == 0);
      dp.obstacle   = ($urandom_range(0, 2) == 0);
      dp.xdir       = dp_x;
      dp.ydir       = dp_y;
      #1;
      e = build_expected(c);
      sb.push_back(e);
      @(posedge clk);
      advance();
    end
    @(negedge clk);
    #3;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    if (!did_py_reset) begin
      checks++;
      failures++;
      $display("FAIL py_reset_reached: got 0, expected 1");
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Monitor: samples the DUT mid-low-phase and retires one scoreboard entry per cycle.
  initial begin
    exp_t        e;
    logic [18:0] act;
    forever begin
      @(negedge clk);
      #2;
      if (sb.size() > 0) begin
        e   = sb.pop_front();
        act = {dp.en_xpos, dp.en_ypos, dp.s_xpos, dp.s_ypos, dp.en_xdir, dp.en_ydir,
               dp.s_xdir, dp.s_ydir, dp.en_timer, dp.s_timer, dp.s_color, dp.s_obs_xy,
               plot, busy, done};
        checks++;
        if (act !== e.ctrl) begin
          failures++;
          $display("FAIL ctrl cyc=%0d: got %b, expected %b", e.cyc, act, e.ctrl);
        end
        checks++;
        if (bounce_count !== e.cnt) begin
          failures++;
          $display("FAIL bounce_count cyc=%0d: got %0d, expected %0d", e.cyc, bounce_count, e.cnt);
        end
      end
    end
  end

endmodule
`default_nettype wire
